// File: rtl/guess_entry.sv
// Keypad front end for the hot-and-cold game: synchronise, debounce and edge-detect
// the raw keypad, assemble up to two decimal digits and submit them as a binary guess.
module guess_entry #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_press,
    input  logic [3:0] key_code,
    input  logic       en,
    output logic [7:0] guess,
    output logic       guess_valid,
    output logic [7:0] entry_bcd,
    output logic [1:0] digit_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;

    logic             sync1_press, sync2_press;
    logic [3:0]       sync1_code, sync2_code;
    logic             stable, stable_d;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       rise_code;
    logic             evt;
    logic [1:0]       state;
    logic [3:0]       tens, ones;
    logic [7:0]       guess_bin;
    logic             accept;
    logic             is_digit;

    // Two-flop synchronisers for the asynchronous keypad level and code
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_press <= 1'b0;
            sync2_press <= 1'b0;
            sync1_code  <= 4'h0;
            sync2_code  <= 4'h0;
        end else begin
            sync1_press <= key_press;
            sync2_press <= sync1_press;
            sync1_code  <= key_code;
            sync2_code  <= sync1_code;
        end
    end

    // Any return to the stable level restarts the count, so short excursions never toggle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable    <= 1'b0;
            stable_d  <= 1'b0;
            cnt       <= '0;
            rise_code <= 4'h0;
            evt       <= 1'b0;
        end else begin
            stable_d <= stable;
            evt      <= stable & ~stable_d;
            if (sync2_press == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= ~stable;
                cnt    <= '0;
                if (!stable) rise_code <= sync2_code;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign accept   = evt & en;
    assign is_digit = (rise_code <= 4'd9);

    // tens*10 + ones as shift-and-add; max 99 fits in 8 bits
    assign guess_bin = {1'b0, tens, 3'b000} + {3'b000, tens, 1'b0} + {4'h0, ones};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= EMPTY;
            tens        <= 4'h0;
            ones        <= 4'h0;
            guess       <= 8'h00;
            guess_valid <= 1'b0;
        end else begin
            guess_valid <= 1'b0;
            if (accept) begin
                if (is_digit) begin
                    case (state)
                        EMPTY: begin
                            tens  <= 4'h0;
                            ones  <= rise_code;
                            state <= ONE;
                        end
                        ONE: begin
                            tens  <= ones;
                            ones  <= rise_code;
                            state <= TWO;
                        end
                        default: ;
                    endcase
                end else if (rise_code == KEY_CLEAR) begin
                    tens  <= 4'h0;
                    ones  <= 4'h0;
                    state <= EMPTY;
                end else if (rise_code == KEY_ENTER && state != EMPTY) begin
                    guess       <= guess_bin;
                    guess_valid <= 1'b1;
                    tens        <= 4'h0;
                    ones        <= 4'h0;
                    state       <= EMPTY;
                end
            end
        end
    end

    assign entry_bcd = {tens, ones};
    assign digit_cnt = state;

endmodule

// File: tb/tb_guess_entry.sv
// Directed and randomized key sequences for guess_entry, checked against a digit-queue model.
module tb_guess_entry;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_press;
    logic [3:0] key_code;
    logic       en;
    logic [7:0] guess;
    logic       guess_valid;
    logic [7:0] entry_bcd;
    logic [1:0] digit_cnt;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic gv_prev = 1'b0;

    logic [3:0] m_digits[$];
    int         m_guess  = 0;
    int         m_pulses = 0;

    guess_entry #(.DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_press  (key_press),
        .key_code   (key_code),
        .en         (en),
        .guess      (guess),
        .guess_valid(guess_valid),
        .entry_bcd  (entry_bcd),
        .digit_cnt  (digit_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse counter, and no two consecutive valid cycles
    always @(negedge clk) begin
        if (guess_valid) begin
            pulses++;
            checks++;
            assert (!gv_prev) else begin
                errors++;
                $error("FAIL valid_back2back: got 1 expected 0");
            end
        end
        gv_prev = guess_valid;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference: the entry is just a list of at most two digits
    task automatic model_key(input logic [3:0] c, input logic e);
        if (!e || c > 4'hB) return;
        if (c == 4'hA) begin
            m_digits.delete();
        end else if (c == 4'hB) begin
            if (m_digits.size() == 1) m_guess = m_digits[0];
            if (m_digits.size() == 2) m_guess = m_digits[0] * 10 + m_digits[1];
            if (m_digits.size() > 0) m_pulses++;
            m_digits.delete();
        end else if (m_digits.size() < 2) begin
            m_digits.push_back(c);
        end
    endtask

    task automatic verify(input string tag);
        logic [7:0] eb;
        eb = 8'h00;
        if (m_digits.size() == 1) eb = {4'h0, m_digits[0]};
        if (m_digits.size() == 2) eb = {m_digits[0], m_digits[1]};
        check({tag, "_cnt"}, 32'(digit_cnt), 32'(m_digits.size()));
        check({tag, "_bcd"}, 32'(entry_bcd), 32'(eb));
        check({tag, "_guess"}, 32'(guess), 32'(m_guess));
        check({tag, "_pulses"}, 32'(pulses), 32'(m_pulses));
    endtask

    // Alternating bounce segments of 1-3 cycles, shorter than the debounce window
    task automatic burst(input logic lvl, input int nseg);
        for (int i = 0; i < nseg; i++) begin
            key_press = (i % 2 == 0) ? lvl : ~lvl;
            cycles($urandom_range(1, 3));
        end
        key_press = lvl;
    endtask

    task automatic do_key(input logic [3:0] c, input int nb, input string tag);
        key_code = c;
        burst(1'b1, nb);
        cycles(10);
        burst(1'b0, nb);
        cycles(10);
        model_key(c, en);
        verify(tag);
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; key_press = 1'b0; key_code = 4'h0;
        #1;
        check("rst_guess", 32'(guess), 0);
        check("rst_valid", 32'(guess_valid), 0);
        check("rst_bcd", 32'(entry_bcd), 0);
        check("rst_cnt", 32'(digit_cnt), 0);
        cycles(2);
        rst = 1'b1;
        cycles(2);

        // Two-digit entry with bounce, then a clean enter for exact latency
        do_key(4'h4, 3, "d4");
        do_key(4'h2, 3, "d42");
        key_code = 4'hB; key_press = 1'b1;
        cycles(7);
        check("lat_e6_valid", 32'(guess_valid), 0);
        check("lat_e6_guess", 32'(guess), 0);
        cycles(1);
        check("lat_e7_valid", 32'(guess_valid), 1);
        check("lat_e7_guess", 32'(guess), 32'h2A);
        check("lat_e7_cnt", 32'(digit_cnt), 0);
        cycles(1);
        check("lat_e8_valid", 32'(guess_valid), 0);
        cycles(6);
        key_press = 1'b0;
        cycles(10);
        model_key(4'hB, 1'b1);
        verify("enter42");

        // Asynchronous reset mid-debounce; held key must debounce from scratch
        key_code = 4'h5; key_press = 1'b1;
        cycles(3);
        #2 rst = 1'b0;
        #1;
        check("arst_guess", 32'(guess), 0);
        check("arst_valid", 32'(guess_valid), 0);
        check("arst_bcd", 32'(entry_bcd), 0);
        check("arst_cnt", 32'(digit_cnt), 0);
        @(negedge clk);
        rst = 1'b1;
        m_guess = 0;
        m_digits.delete();
        cycles(7);
        check("arst_e6_cnt", 32'(digit_cnt), 0);
        cycles(1);
        check("arst_e7_cnt", 32'(digit_cnt), 1);
        check("arst_e7_bcd", 32'(entry_bcd), 32'h05);
        key_press = 1'b0;
        cycles(10);
        model_key(4'h5, 1'b1);
        verify("arst_key");
        do_key(4'hA, 2, "arst_clr");

        // Overflow and single digit
        do_key(4'h9, 2, "ov9a");
        do_key(4'h9, 2, "ov9b");
        do_key(4'h7, 2, "ov7");
        do_key(4'hB, 2, "ov_ent");
        do_key(4'h5, 1, "sd5");
        do_key(4'hB, 1, "sd_ent");
        do_key(4'hB, 1, "empty_ent");

        // Clear behaviour
        do_key(4'h3, 0, "c3");
        do_key(4'hA, 0, "c_clr");
        do_key(4'hB, 0, "c_ent");
        do_key(4'h3, 0, "c3b");
        do_key(4'hA, 0, "c_clr2");
        do_key(4'h8, 0, "c8");
        do_key(4'hB, 0, "c_ent8");

        // Short pulses rejected, exactly-D clean press accepted
        key_code = 4'h1;
        for (int w = 1; w <= 3; w++) begin
            key_press = 1'b1;
            cycles(w);
            key_press = 1'b0;
            cycles(8);
            check($sformatf("glitch%0d_cnt", w), 32'(digit_cnt), 0);
        end
        key_press = 1'b1;
        cycles(4);
        key_press = 1'b0;
        cycles(10);
        model_key(4'h1, 1'b1);
        verify("clean4");
        do_key(4'hA, 0, "g_clr");

        // Enable gating and unused codes
        en = 1'b0;
        do_key(4'h6, 1, "en0_6");
        do_key(4'hB, 1, "en0_ent");
        en = 1'b1;
        for (int c = 12; c < 16; c++) do_key(4'(c), 1, $sformatf("unused%0h", c));
        do_key(4'h6, 1, "en1_6");
        do_key(4'hB, 1, "en1_ent");

        // Randomized key stream
        for (int i = 0; i < 40; i++) begin
            logic [3:0] c;
            int r;
            r = $urandom_range(0, 9);
            if (r < 6) c = 4'($urandom_range(0, 9));
            else if (r < 8) c = 4'hB;
            else c = 4'($urandom_range(10, 15));
            en = ($urandom_range(0, 7) != 0);
            do_key(c, $urandom_range(0, 4), $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/guess_entry.md
# guess_entry

Upstream front end of the hot-and-cold game core. Converts the raw, bouncy keypad strobe and 4-bit key code into clean key events, assembles up to two decimal digits into a binary guess (0–99) and presents it to the game comparator as an 8-bit value with a one-cycle valid pulse. Also exports the in-progress digits in BCD so the 7-segment stage can echo entry before it is submitted.

## Interface
- DEBOUNCE_CYCLES, 4 (sim) / 500000 (board), consecutive synchronised cycles a level change must persist before it is accepted; minimum 2
- CNT_W, 20, debounce counter width; must hold DEBOUNCE_CYCLES-1
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- key_press  input  1  raw key-down level, asynchronous to clk, may bounce
- key_code  input  4  raw key code, valid while key_press high: 0–9 digit, 0xA clear, 0xB enter, 0xC–0xF unused
- en  input  1  entry enable; low = game locked, key events discarded
- guess  output  8  last submitted guess, binary 0–99, held until next submit
- guess_valid  output  1  single-cycle pulse, guess updated in same cycle
- entry_bcd  output  8  in-progress digits, [7:4] tens, [3:0] ones
- digit_cnt  output  2  digits currently entered: 0, 1 or 2

## Operation
- Synchroniser: key_press and key_code each pass through two flops (sync1, sync2).
- Debouncer: register `stable` (reset 0) and counter (reset 0). Each cycle sync2 press == stable: counter cleared. Differs and counter < DEBOUNCE_CYCLES-1: counter increments. Differs and counter == DEBOUNCE_CYCLES-1: stable toggles, counter cleared.
- Key event: registered pulse, set the cycle after stable rises (stable & ~stable_d); key code captured from sync2 code in the cycle stable rises. Falling edge of stable generates nothing. Holding a key produces exactly one event.
- Events with en low, or codes 0xC–0xF, are discarded with no state change.
- Entry FSM states EMPTY (digit_cnt 0), ONE (1), TWO (2):
  - EMPTY + digit d -> ONE; ones=d, tens=0.
  - ONE + digit d -> TWO; tens=ones, ones=d.
  - TWO + digit -> ignored (stays TWO, entry unchanged).
  - any + clear -> EMPTY; entry_bcd=0; guess unchanged, no pulse.
  - EMPTY + enter -> ignored, no pulse.
  - ONE/TWO + enter -> guess = tens*10 + ones (computed in 8 bits, max 99), guess_valid pulses, -> EMPTY, entry_bcd=0.
- en deasserting mid-entry does not clear the entry; it only blocks further events.

## Timing
- Reset (rst low, async): stable, counter, sync flops, event, FSM=EMPTY, guess=0, guess_valid=0, entry_bcd=0, digit_cnt=0, all immediately, independent of clk. Release takes effect on the next rising edge.
- Latency, with edge 0 the first edge at which sync1 samples key_press high and the level held clean: sync2 high after edge 1; stable high after edge 1+DEBOUNCE_CYCLES; event high after edge 2+DEBOUNCE_CYCLES; FSM/outputs update at edge 3+DEBOUNCE_CYCLES. guess_valid is high for exactly the cycle between edges 3+D and 4+D. D=4: valid between edges 7 and 8.
- Glitch rejection: a high or low excursion of sync2 lasting fewer than DEBOUNCE_CYCLES cycles never changes stable.
- Minimum key-to-key spacing: release and re-press each need DEBOUNCE_CYCLES clean cycles; no event is lost or duplicated at that spacing.
- guess_valid never asserts on two consecutive cycles.

## Test plan
- Reset: hold rst low mid-debounce with key down -> all outputs 0 without a clock edge; after release, key still held must debounce from counter 0 before any event.
- Two-digit submit, D=4: press/release 4, 2, enter, each held 10 cycles with 3-cycle bounce bursts -> entry_bcd 0x04 then 0x42, digit_cnt 1 then 2, guess=42 (0x2A) with one guess_valid pulse at edge 7 after enter's first sampled high; digit_cnt 0.
- Overflow/single digit: keys 9,9,7,enter -> 7 ignored, guess=99; then 5,enter -> guess=5; enter alone -> no pulse, guess stays 5.
- Clear: 3,clear,enter -> no pulse, guess unchanged; 3,clear,8,enter -> guess=8.
- Bounce rejection: key_press pulses of 1–3 cycles (D=4) with code 1 -> no event, digit_cnt stays 0; a 4-cycle-clean press -> exactly one event.
- Enable and unused codes: en=0 during 6,enter -> no change; codes 0xC–0xF with en=1 -> no change; en=1, 6, enter -> guess=6.
